addsub_issuer: RTL

- Initiator-side sequencer for the packed dual-lane 4-bit add/sub unit.
- Accepts operation requests from upstream over a valid/ready handshake and launches each one on the unit.
- Holds the unit's operands stable until the unit reports done, then returns the result downstream over a second valid/ready handshake.
- Rejects illegal opcodes locally and reports a timeout if the unit never completes.

---
 rtl/addsub_issuer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/addsub_issuer.sv
// Initiator-side sequencer for the dual-lane 4-bit add/sub unit: accepts a request,
// holds operands on the unit until it reports done, then returns the result.
module addsub_issuer #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned BLANK   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic [1:0] req_op,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [1:0] rsp_code,
  output logic       busy,
  output logic [7:0] au_in1,
  output logic [7:0] au_in2,
  output logic [1:0] au_op,
  input  logic [7:0] au_out,
  input  logic       au_done
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] BLANK_C   = CW'(BLANK);
  localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] TMO_SAT   = CW'(TIMEOUT);

  localparam logic [1:0] CODE_OK      = 2'b00;
  localparam logic [1:0] CODE_ILLEGAL = 2'b01;
  localparam logic [1:0] CODE_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    au_in1_q, au_in1_d;
  logic [7:0]    au_in2_q, au_in2_d;
  logic [1:0]    au_op_q, au_op_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rsp_data_q, rsp_data_d;
  logic [1:0]    rsp_code_q, rsp_code_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    au_in1_d    = au_in1_q;
    au_in2_d    = au_in2_q;
    au_op_d     = au_op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_code_d  = rsp_code_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (!req_op[1]) begin
            au_in1_d = req_a;
            au_in2_d = req_b;
            au_op_d  = req_op;
            cnt_d    = '0;
            state_d  = S_WAIT;
          end else begin
            // Illegal opcode: answer locally, unit operands keep the last legal launch.
            rsp_data_d  = '0;
            rsp_code_d  = CODE_ILLEGAL;
            rsp_valid_d = 1'b1;
            state_d     = S_RESP;
          end
        end
      end
      S_WAIT: begin
        // Done is checked before timeout so a completion on the last cycle still wins.
        if (cnt_q >= BLANK_C && au_done) begin
          rsp_data_d  = au_out;
          rsp_code_d  = CODE_OK;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else if (cnt_q >= TMO_LAST) begin
          rsp_data_d  = '0;
          rsp_code_d  = CODE_TIMEOUT;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
        if (cnt_q != TMO_SAT) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      au_in1_q    <= '0;
      au_in2_q    <= '0;
      au_op_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      au_in1_q    <= au_in1_d;
      au_in2_q    <= au_in2_d;
      au_op_q     <= au_op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_code_q  <= rsp_code_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_code  = rsp_code_q;
  assign au_in1    = au_in1_q;
  assign au_in2    = au_in2_q;
  assign au_op     = au_op_q;

endmodule
